// File: rtl/fp_unit.sv
// fp_unit -- single-cycle binary32 helper unit: compare, int<->float
// conversion and optional raw bit moves. All other FP ops return 0/0.
//
// Optional feature macro: FP_UNIT_FMV_EN (raw moves fmv_i2f / fmv_f2i).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   data1, data2        operands (data3, fmt unused)
//   rm                  rounding mode / compare predicate select
//   op_*                operation selects (priority: fcmp, fcvt_i2f,
//                       fcvt_f2i, fmv_i2f, fmv_f2i)
//   op_fcvt_op[0]       0 signed int32, 1 unsigned uint32
//   enable              operation valid this cycle
//   result, flags       registered result and {NV,DZ,OF,UF,NX}
module fp_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic [1:0]  fmt,
  input  logic [2:0]  rm,
  input  logic        op_fmadd,
  input  logic        op_fadd,
  input  logic        op_fsub,
  input  logic        op_fmul,
  input  logic        op_fdiv,
  input  logic        op_fsqrt,
  input  logic        op_fmv_i2f,
  input  logic        op_fmv_f2i,
  input  logic        op_fcmp,
  input  logic        op_fcvt_i2f,
  input  logic        op_fcvt_f2i,
  input  logic [1:0]  op_fcvt_op,
  input  logic        enable,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  // Round-increment decision from sign, lsb, guard and sticky.
  function automatic logic round_up(input logic [2:0] mode, input logic sign,
                                    input logic lsb, input logic guard,
                                    input logic sticky);
    case (mode)
      3'd1:    round_up = 1'b0;                     // RTZ
      3'd2:    round_up = sign & (guard | sticky);  // RDN
      3'd3:    round_up = ~sign & (guard | sticky); // RUP
      3'd4:    round_up = guard;                    // RMM
      default: round_up = guard & (sticky | lsb);   // RNE (and 5-7)
    endcase
  endfunction

  // Leading-zero count of a nonzero 32-bit word.
  function automatic logic [4:0] lzc32(input logic [31:0] x);
    lzc32 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) lzc32 = 5'(31 - i);
    end
  endfunction

  logic        unused_inputs_s;
  logic        cmp_a_nan_s, cmp_b_nan_s, cmp_any_snan_s, cmp_zero_s;
  logic        cmp_eq_s, cmp_lt_s, cmp_result_s, cmp_nv_s;
  logic        i2f_neg_s, i2f_inc_s;
  logic [31:0] i2f_mag_s, i2f_norm_s, i2f_result_s;
  logic [4:0]  i2f_lz_s;
  logic [24:0] i2f_sum_s;
  logic [7:0]  i2f_exp_s;
  logic        f2i_sign_s, f2i_nan_s, f2i_big_s, f2i_tiny_s, f2i_uns_s;
  logic        f2i_guard_s, f2i_sticky_s, f2i_inc_s, f2i_invalid_s, f2i_pos_s;
  logic [7:0]  f2i_exp_s;
  logic [23:0] f2i_sig_s;
  logic [5:0]  f2i_shamt_s;
  logic [63:0] f2i_wide_s;
  logic [31:0] f2i_int_s, f2i_sat_s, f2i_result_s;
  logic [32:0] f2i_mag_s;
  logic [31:0] next_result_s, result_r;
  logic [4:0]  next_flags_s, flags_r;

  assign unused_inputs_s = ^{data3, fmt, op_fcvt_op[1], op_fmadd, op_fadd, op_fsub,
                             op_fmul, op_fdiv, op_fsqrt, op_fmv_i2f, op_fmv_f2i};

  // ---------------- compare ----------------
  assign cmp_a_nan_s    = (&data1[30:23]) & (|data1[22:0]);
  assign cmp_b_nan_s    = (&data2[30:23]) & (|data2[22:0]);
  assign cmp_any_snan_s = (cmp_a_nan_s & ~data1[22]) | (cmp_b_nan_s & ~data2[22]);
  assign cmp_zero_s     = ~(|data1[30:0]) & ~(|data2[30:0]);
  assign cmp_eq_s       = cmp_zero_s | (data1 == data2);

  // Sign-magnitude ordering; both-zero makes +0 and -0 equal.
  always_comb begin
    cmp_lt_s = 1'b0;
    if (cmp_zero_s) begin
      cmp_lt_s = 1'b0;
    end else if (data1[31] != data2[31]) begin
      cmp_lt_s = data1[31];
    end else if (data1[31]) begin
      cmp_lt_s = data1[30:0] > data2[30:0];
    end else begin
      cmp_lt_s = data1[30:0] < data2[30:0];
    end
  end

  // Predicate select and invalid flag; NaN always yields 0.
  always_comb begin
    cmp_result_s = 1'b0;
    cmp_nv_s     = 1'b0;
    if (cmp_a_nan_s | cmp_b_nan_s) begin
      case (rm)
        3'd0, 3'd1: cmp_nv_s = 1'b1;
        3'd2:       cmp_nv_s = cmp_any_snan_s;
        default:    cmp_nv_s = 1'b0;
      endcase
    end else begin
      case (rm)
        3'd0:    cmp_result_s = cmp_lt_s | cmp_eq_s;
        3'd1:    cmp_result_s = cmp_lt_s;
        3'd2:    cmp_result_s = cmp_eq_s;
        default: cmp_result_s = 1'b0;
      endcase
    end
  end

  // ---------------- int -> float ----------------
  // Normalise magnitude so bit 31 is the hidden one; bits 7:0 are guard/sticky.
  assign i2f_neg_s    = ~op_fcvt_op[0] & data1[31];
  assign i2f_mag_s    = i2f_neg_s ? (~data1 + 32'd1) : data1;
  assign i2f_lz_s     = lzc32(i2f_mag_s);
  assign i2f_norm_s   = i2f_mag_s << i2f_lz_s;
  assign i2f_inc_s    = round_up(rm, i2f_neg_s, i2f_norm_s[8], i2f_norm_s[7], |i2f_norm_s[6:0]);
  assign i2f_sum_s    = {1'b0, i2f_norm_s[31:8]} + {24'd0, i2f_inc_s};
  // Mantissa carry-out bumps the exponent; the low 23 bits are then zero.
  assign i2f_exp_s    = 8'd158 - {3'd0, i2f_lz_s} + {7'd0, i2f_sum_s[24]};
  assign i2f_result_s = (i2f_mag_s == 32'd0) ? 32'd0 : {i2f_neg_s, i2f_exp_s, i2f_sum_s[22:0]};

  // ---------------- float -> int ----------------
  assign f2i_sign_s  = data1[31];
  assign f2i_exp_s   = data1[30:23];
  assign f2i_nan_s   = (&f2i_exp_s) & (|data1[22:0]);
  assign f2i_sig_s   = {|f2i_exp_s, data1[22:0]};
  assign f2i_big_s   = f2i_exp_s > 8'd158;   // |x| >= 2^32, also inf/NaN
  assign f2i_tiny_s  = f2i_exp_s < 8'd126;   // |x| < 0.5
  assign f2i_shamt_s = 6'(f2i_exp_s - 8'd118);
  assign f2i_uns_s   = op_fcvt_op[0];

  // Fixed point with 32 fraction bits: integer part, guard bit, sticky.
  always_comb begin
    f2i_wide_s   = 64'd0;
    f2i_int_s    = 32'd0;
    f2i_guard_s  = 1'b0;
    f2i_sticky_s = 1'b0;
    if (f2i_big_s) begin
      f2i_int_s = 32'd0;
    end else if (f2i_tiny_s) begin
      f2i_sticky_s = |f2i_sig_s;
    end else begin
      f2i_wide_s   = {40'd0, f2i_sig_s} << f2i_shamt_s;
      f2i_int_s    = f2i_wide_s[63:32];
      f2i_guard_s  = f2i_wide_s[31];
      f2i_sticky_s = |f2i_wide_s[30:0];
    end
  end

  assign f2i_inc_s = round_up(rm, f2i_sign_s, f2i_int_s[0], f2i_guard_s, f2i_sticky_s);
  assign f2i_mag_s = {1'b0, f2i_int_s} + {32'd0, f2i_inc_s};

  // Range check on the rounded magnitude.
  always_comb begin
    f2i_invalid_s = 1'b0;
    if (f2i_big_s) begin
      f2i_invalid_s = 1'b1;
    end else if (f2i_uns_s) begin
      f2i_invalid_s = f2i_sign_s ? (f2i_mag_s != 33'd0) : f2i_mag_s[32];
    end else begin
      f2i_invalid_s = f2i_sign_s ? (f2i_mag_s > 33'h0_8000_0000) : (f2i_mag_s > 33'h0_7FFF_FFFF);
    end
  end

  // NaN saturates like positive overflow.
  assign f2i_pos_s    = f2i_nan_s | ~f2i_sign_s;
  assign f2i_sat_s    = f2i_uns_s ? (f2i_pos_s ? 32'hFFFF_FFFF : 32'h0000_0000)
                                  : (f2i_pos_s ? 32'h7FFF_FFFF : 32'h8000_0000);
  assign f2i_result_s = f2i_sign_s ? (~f2i_mag_s[31:0] + 32'd1) : f2i_mag_s[31:0];

  // ---------------- operation select ----------------
  // Priority mux; anything not selected (or unsupported) produces 0/0.
  always_comb begin
    next_result_s = 32'd0;
    next_flags_s  = 5'd0;
    if (!enable) begin
      next_result_s = 32'd0;
    end else if (op_fcmp) begin
      next_result_s = {31'd0, cmp_result_s};
      next_flags_s  = {cmp_nv_s, 4'd0};
    end else if (op_fcvt_i2f) begin
      next_result_s = i2f_result_s;
      next_flags_s  = {4'd0, |i2f_norm_s[7:0]};
    end else if (op_fcvt_f2i) begin
      if (f2i_invalid_s) begin
        next_result_s = f2i_sat_s;
        next_flags_s  = 5'b10000;
      end else begin
        next_result_s = f2i_result_s;
        next_flags_s  = {4'd0, f2i_guard_s | f2i_sticky_s};
      end
`ifdef FP_UNIT_FMV_EN
    end else if (op_fmv_i2f || op_fmv_f2i) begin
      next_result_s = data1;
      next_flags_s  = 5'd0;
`endif
    end else begin
      next_result_s = 32'd0;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      result_r <= 32'd0;
      flags_r  <= 5'd0;
    end else begin
      result_r <= next_result_s;
      flags_r  <= next_flags_s;
    end
  end

  assign result = result_r;
  assign flags  = flags_r;

endmodule

// File: tb/tb_fp_unit.sv
// Randomised bench for fp_unit with a value-level reference model.
module tb_fp_unit;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] a, b, c;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [1:0]  cop;
    logic        cmp, i2f, f2i, mvi, mvf;
    logic [5:0]  unsup;
  } stim_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  stim_t cur;
  int vectors = 0;
  int miscompares = 0;

  logic        reset, enable;
  logic [31:0] data1, data2, data3, result;
  logic [1:0]  fmt, op_fcvt_op;
  logic [2:0]  rm;
  logic [4:0]  flags;

  assign reset = cur.rst;  assign enable = cur.en;
  assign data1 = cur.a;    assign data2 = cur.b;   assign data3 = cur.c;
  assign fmt = cur.fmt;    assign rm = cur.rm;     assign op_fcvt_op = cur.cop;

  fp_unit dut (
    .clock(clock), .reset(reset), .data1(data1), .data2(data2), .data3(data3),
    .fmt(fmt), .rm(rm),
    .op_fmadd(cur.unsup[0]), .op_fadd(cur.unsup[1]), .op_fsub(cur.unsup[2]),
    .op_fmul(cur.unsup[3]), .op_fdiv(cur.unsup[4]), .op_fsqrt(cur.unsup[5]),
    .op_fmv_i2f(cur.mvi), .op_fmv_f2i(cur.mvf), .op_fcmp(cur.cmp),
    .op_fcvt_i2f(cur.i2f), .op_fcvt_f2i(cur.f2i), .op_fcvt_op(op_fcvt_op),
    .enable(enable), .result(result), .flags(flags)
  );

  // ---------------- reference model ----------------
  // rel: -1 remainder below half, 0 exact tie, 1 above half.
  function automatic logic rnd_up(input logic [2:0] mode, input logic neg, input logic odd,
                                  input int rel, input logic inexact);
    case (mode)
      3'd1:    return 1'b0;
      3'd2:    return neg & inexact;
      3'd3:    return !neg & inexact;
      3'd4:    return inexact && rel >= 0;
      default: return inexact && (rel > 0 || (rel == 0 && odd));
    endcase
  endfunction

  function automatic longint key(input logic [31:0] x);
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction

  function automatic void m_cmp(input logic [31:0] a, b, input logic [2:0] mode,
                                output logic [31:0] r, output logic [4:0] f);
    logic an, bn, sn, lt, eq;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sn = (an && !a[22]) || (bn && !b[22]);
    r = 32'd0; f = 5'd0;
    if (an || bn) begin
      if (mode == 3'd0 || mode == 3'd1) f = 5'h10;
      else if (mode == 3'd2 && sn) f = 5'h10;
      return;
    end
    lt = key(a) < key(b);
    eq = key(a) == key(b);
    if (mode == 3'd0) r = {31'd0, lt | eq};
    else if (mode == 3'd1) r = {31'd0, lt};
    else if (mode == 3'd2) r = {31'd0, eq};
  endfunction

  function automatic void m_i2f(input logic [31:0] a, input logic uns, input logic [2:0] mode,
                                output logic [31:0] r, output logic [4:0] f);
    longint v, mag, q, rem, half;
    int k, rel;
    logic neg;
    v = uns ? longint'({32'd0, a}) : longint'($signed(a));
    neg = v < 64'sd0;
    mag = neg ? -v : v;
    r = 32'd0; f = 5'd0;
    if (mag == 64'sd0) return;
    k = 0;
    while ((mag >> (k + 1)) != 64'sd0) k++;
    rem = 64'sd0; rel = -1;
    if (k <= 23) q = mag << (23 - k);
    else begin
      q = mag >> (k - 23);
      rem = mag - (q << (k - 23));
      half = 64'sd1 << (k - 24);
      rel = (rem > half) ? 1 : (rem == half) ? 0 : -1;
    end
    if (rnd_up(mode, neg, q[0], rel, rem != 64'sd0)) q++;
    if (q == (64'sd1 << 24)) begin q = 64'sd1 << 23; k++; end
    r = {neg, 8'(127 + k), 23'(q)};
    f = {4'd0, rem != 64'sd0};
  endfunction

  function automatic void m_f2i(input logic [31:0] a, input logic uns, input logic [2:0] mode,
                                output logic [31:0] r, output logic [4:0] f);
    longint sig, q, rem, half, val, lo, hi;
    int scale, sh, rel;
    logic neg, inexact;
    neg = a[31];
    lo = uns ? 64'sd0 : -(64'sd1 <<< 31);
    hi = uns ? ((64'sd1 <<< 32) - 64'sd1) : ((64'sd1 <<< 31) - 64'sd1);
    if (a[30:23] == 8'hFF) begin
      f = 5'h10;
      r = (a[22:0] != 23'd0 || !neg) ? 32'(hi) : 32'(lo);
      return;
    end
    sig = longint'(a[22:0]) + ((a[30:23] != 8'd0) ? (64'sd1 << 23) : 64'sd0);
    scale = ((a[30:23] == 8'd0) ? 1 : int'(a[30:23])) - 150;
    inexact = 1'b0; rel = -1;
    if (scale >= 0) q = (scale > 40) ? (64'sd1 << 50) : (sig << scale);
    else begin
      sh = -scale;
      if (sh >= 40) begin q = 64'sd0; inexact = sig != 64'sd0; end
      else begin
        q = sig >> sh;
        rem = sig - (q << sh);
        half = 64'sd1 << (sh - 1);
        rel = (rem > half) ? 1 : (rem == half) ? 0 : -1;
        inexact = rem != 64'sd0;
      end
    end
    if (rnd_up(mode, neg, q[0], rel, inexact)) q++;
    val = neg ? -q : q;
    if (val > hi) begin r = 32'(hi); f = 5'h10; end
    else if (val < lo) begin r = 32'(lo); f = 5'h10; end
    else begin r = 32'(val); f = {4'd0, inexact}; end
  endfunction

  function automatic void model(input stim_t s, output logic [31:0] r, output logic [4:0] f);
    r = 32'd0; f = 5'd0;
    if (!s.rst || !s.en) return;
    if (s.cmp) m_cmp(s.a, s.b, s.rm, r, f);
    else if (s.i2f) m_i2f(s.a, s.cop[0], s.rm, r, f);
    else if (s.f2i) m_f2i(s.a, s.cop[0], s.rm, r, f);
`ifdef FP_UNIT_FMV_EN
    else if (s.mvi || s.mvf) r = s.a;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.en = 1'b1; s.a = 32'd0; s.b = 32'd0; s.c = 32'd0;
    s.fmt = 2'd0; s.rm = 3'd0; s.cop = 2'd0;
    s.cmp = 1'b0; s.i2f = 1'b0; s.f2i = 1'b0; s.mvi = 1'b0; s.mvf = 1'b0;
    s.unsup = 6'd0;
    return s;
  endfunction

  function automatic logic [31:0] rfloat();
    logic [31:0] sp [12];
    logic s;
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
           32'hFFA00000, 32'h00000001, 32'h4F800000, 32'hCF000000, 32'h3F000000, 32'hBF000000};
    s = 1'($urandom);
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return {s, 8'($urandom_range(110, 165)), 23'($urandom)};
      2: return sp[$urandom_range(0, 11)];
      3: return {s, 8'($urandom_range(125, 135)), 23'($urandom) & 23'h7F0000};
      4: return {s, 8'd0, 23'($urandom)};
      default: return {s, 8'($urandom_range(156, 159)), 23'($urandom_range(0, 3))};
    endcase
  endfunction

  function automatic logic [31:0] rint();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom >> $urandom_range(0, 31);
      2: return 32'h80000000 + 32'($urandom_range(0, 2)) - 32'd1;
      default: return 32'd0 - 32'($urandom_range(0, 300));
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int k;
    s = idle();
    s.rst = $urandom_range(0, 39) != 0;
    s.en  = $urandom_range(0, 15) != 0;
    s.rm  = 3'($urandom); s.cop = 2'($urandom); s.fmt = 2'($urandom); s.c = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0, 1:    s.cmp = 1'b1;
      2, 3:    s.i2f = 1'b1;
      4, 5, 6: s.f2i = 1'b1;
      7:       s.mvi = 1'b1;
      8:       s.mvf = 1'b1;
      9:       s.unsup = 6'd1 << $urandom_range(0, 5);
      10: begin
        s.cmp = 1'($urandom); s.i2f = 1'($urandom); s.f2i = 1'($urandom);
        s.mvi = 1'($urandom); s.mvf = 1'($urandom); s.unsup = 6'($urandom);
      end
      default: ;
    endcase
    s.a = (s.i2f && !s.cmp) ? rint() : rfloat();
    case ($urandom_range(0, 3))
      0: s.b = rfloat();
      1: s.b = s.a;
      2: s.b = s.a ^ 32'h80000000;
      default: s.b = s.a + 32'd1;
    endcase
    return s;
  endfunction

  // Pins the model to hand-computed values, then sends the vector to the DUT.
  task automatic pin(input string name, input int op, input logic [2:0] mode, input logic uns,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                     input logic [4:0] ef);
    stim_t s;
    logic [31:0] r;
    logic [4:0] f;
    s = idle();
    s.rm = mode; s.cop = {1'b0, uns}; s.a = a; s.b = b;
    case (op)
      0: s.cmp = 1'b1;
      1: s.i2f = 1'b1;
      2: s.f2i = 1'b1;
      default: s.unsup = 6'b000010;
    endcase
    model(s, r, f);
    vectors++;
    if (r !== er || f !== ef) begin
      miscompares++;
      $display("FAIL pin %s: model result=%h flags=%h, required result=%h flags=%h", name, r, f, er, ef);
    end
    @(negedge clock);
    cur = s;
  endtask

  // Single compare process: expectation from the inputs present at each edge.
  initial begin
    logic [31:0] er;
    logic [4:0]  ef;
    forever begin
      @(posedge clock);
      model(cur, er, ef);
      #1;
      vectors++;
      if (result !== er || flags !== ef) begin
        miscompares++;
        $display("FAIL dut t=%0t: result=%h flags=%h, expected result=%h flags=%h (a=%h b=%h rm=%0d)",
                 $time, result, flags, er, ef, cur.a, cur.b, cur.rm);
      end
    end
  end

  initial begin
    stim_t s;
    cur = idle();
    cur.rst = 1'b0; cur.cmp = 1'b1; cur.a = 32'h3F800000; cur.b = 32'h40000000; cur.rm = 3'd1;
    repeat (3) @(negedge clock);

    pin("cmp_lt",      0, 3'd1, 1'b0, 32'h3F800000, 32'h40000000, 32'h00000001, 5'h00);
    pin("cmp_eq_zero", 0, 3'd2, 1'b0, 32'h80000000, 32'h00000000, 32'h00000001, 5'h00);
    pin("cmp_eq_qnan", 0, 3'd2, 1'b0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h00);
    pin("cmp_lt_qnan", 0, 3'd1, 1'b0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h10);
    pin("cmp_eq_snan", 0, 3'd2, 1'b0, 32'h7F800001, 32'h3F800000, 32'h00000000, 5'h10);
    pin("i2f_rne",     1, 3'd0, 1'b0, 32'h01000001, 32'h0, 32'h4B800000, 5'h01);
    pin("i2f_rup",     1, 3'd3, 1'b0, 32'h01000001, 32'h0, 32'h4B800001, 5'h01);
    pin("i2f_u_rtz",   1, 3'd1, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h4F7FFFFF, 5'h01);
    pin("i2f_min",     1, 3'd0, 1'b0, 32'h80000000, 32'h0, 32'hCF000000, 5'h00);
    pin("f2i_rne",     2, 3'd0, 1'b0, 32'hBFC00000, 32'h0, 32'hFFFFFFFE, 5'h01);
    pin("f2i_rtz",     2, 3'd1, 1'b0, 32'hBFC00000, 32'h0, 32'hFFFFFFFF, 5'h01);
    pin("f2i_u_neg",   2, 3'd1, 1'b1, 32'hBFC00000, 32'h0, 32'h00000000, 5'h10);
    pin("f2i_u_tiny",  2, 3'd1, 1'b1, 32'hBE99999A, 32'h0, 32'h00000000, 5'h01);
    pin("f2i_ovf",     2, 3'd0, 1'b0, 32'h4F000000, 32'h0, 32'h7FFFFFFF, 5'h10);
    pin("f2i_u_nan",   2, 3'd0, 1'b1, 32'h7FC00000, 32'h0, 32'hFFFFFFFF, 5'h10);
    pin("fadd_unsup",  3, 3'd0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'h00);

    // Back-to-back stream, then reset mid-stream, then enable low.
    for (int i = 0; i < 6; i++) begin
      s = rand_stim(); s.rst = 1'b1; s.en = 1'b1;
      @(negedge clock); cur = s;
    end
    s = rand_stim(); s.rst = 1'b0; s.en = 1'b1; s.f2i = 1'b1;
    @(negedge clock); cur = s;
    s = rand_stim(); s.rst = 1'b1; s.en = 1'b0; s.i2f = 1'b1;
    @(negedge clock); cur = s;

    for (int i = 0; i < 4000; i++) begin
      s = rand_stim();
      @(negedge clock); cur = s;
    end
    @(negedge clock);
    cur = idle(); cur.en = 1'b0;
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
